// File: rtl/floo_mcast_fork_pkg.sv
// Shared types for the multicast fork stage.
package floo_mcast_fork_pkg;

    // Packet-lock state: Idle takes its mask from the head flit, Locked replays the stored mask.
    typedef enum logic {
        ForkIdle   = 1'b0,
        ForkLocked = 1'b1
    } fork_state_e;

endpackage

// File: rtl/floo_mcast_fork_if.sv
// Handshake bundle of the multicast fork: one upstream stream fanned out to NumOutputs ports.
// Signal directions in the names are those seen by the fork itself.
interface floo_mcast_fork_if #(
    parameter int unsigned NumOutputs = 5,
    parameter type         flit_t     = logic
);
    logic                  valid_i;
    logic                  ready_o;
    flit_t                 data_i;
    logic                  last_i;
    logic [NumOutputs-1:0] mask_i;
    logic [NumOutputs-1:0] valid_o;
    logic [NumOutputs-1:0] ready_i;
    flit_t                 data_o;
    logic                  last_o;

    // The fork side.
    modport slave (
        input  valid_i, data_i, last_i, mask_i, ready_i,
        output ready_o, valid_o, data_o, last_o
    );

    // The environment side: upstream source plus downstream sinks.
    modport master (
        output valid_i, data_i, last_i, mask_i, ready_i,
        input  ready_o, valid_o, data_o, last_o
    );
endinterface

// File: rtl/floo_mcast_fork_pending.sv
// Per-output pending tracker for a replicated flit. A set pend bit means that output
// has not yet taken the current flit; the flit retires once every selected output has.
module floo_mcast_pending #(
    parameter int unsigned NumOutputs = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    input  logic [NumOutputs-1:0] eff_i,
    input  logic [NumOutputs-1:0] ready_i,
    output logic [NumOutputs-1:0] valid_o,
    output logic                  ready_o
);

    logic [NumOutputs-1:0] pend_q;
    logic [NumOutputs-1:0] pend_d;
    logic [NumOutputs-1:0] done;

    // Fan-out valids, all-done reduction and the next pending set.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        pend_d  = pend_q;
        valid_o = {NumOutputs{valid_i}} & eff_i & pend_q;
        done    = ~eff_i | ~pend_q | ready_i;
        ready_o = valid_i & (&done);
        if (ready_o) begin
            pend_d = '1;
        end else if (valid_i) begin
            pend_d = pend_q & ~(valid_o & ready_i);
        end
    end

    // Pending register; all ones means nobody has taken the current flit yet.
    always_ff @(posedge clk_i) begin
        // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst_i) begin
            pend_q <= '1;
        end else begin
            pend_q <= pend_d;
        end
    end

    // An output may only be retired if it was actually a destination of the flit.
    a_pend_within_eff: assert property (@(posedge clk_i) disable iff (rst_i)
        ((pend_q & ~pend_d & ~eff_i) == '0));

endmodule

// File: rtl/floo_mcast_fork.sv
// Multicast replication stage with wormhole mask locking. The head flit's mask is
// latched for the whole packet; each flit is offered to all selected outputs and
// retires once all of them have taken it. Flits with no destination are dropped
// and counted.
module floo_mcast_fork
    import floo_mcast_fork_pkg::*;
#(
    parameter int unsigned NumOutputs = 5,
    parameter type         flit_t     = logic,
    parameter int unsigned InPort     = 0,
    parameter bit          NoLoopback = 1'b1,
    parameter int unsigned CntWidth   = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    floo_mcast_fork_if.slave    bus,
    output logic                busy_o,
    output logic [CntWidth-1:0] drop_cnt_o
);

    // Bit of the mask pointing back at our own port, cleared on heads when loopback is off.
    localparam logic [NumOutputs-1:0] LoopMask =
        NoLoopback ? (NumOutputs'(1) << InPort) : '0;

    fork_state_e           state_q;
    fork_state_e           state_d;
    logic [NumOutputs-1:0] lock_q;
    logic [NumOutputs-1:0] lock_d;
    logic [NumOutputs-1:0] head_mask;
    logic [NumOutputs-1:0] eff;
    logic                  transfer;
    logic                  drop;
    logic [CntWidth-1:0]   drop_cnt_q;
    flit_t                 flit;

    assign head_mask = bus.mask_i & ~LoopMask;
    assign eff       = (state_q == ForkLocked) ? lock_q : head_mask;

    floo_mcast_pending #(
        .NumOutputs (NumOutputs)
    ) i_pending (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (bus.valid_i),
        .eff_i   (eff),
        .ready_i (bus.ready_i),
        .valid_o (bus.valid_o),
        .ready_o (transfer)
    );

    // The payload is broadcast untouched; only valid/ready are per output.
    assign flit        = bus.data_i;
    assign bus.data_o  = flit;
    assign bus.last_o  = bus.last_i;
    assign bus.ready_o = transfer;

    // An empty effective mask consumes the flit at once (transfer is high then too).
    assign drop       = bus.valid_i & ~(|eff);
    assign busy_o     = (state_q == ForkLocked);
    assign drop_cnt_o = drop_cnt_q;

    // Packet lock: a non-tail head locks its mask, the tail releases it.
    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        if (transfer) begin
            unique case (state_q)
                ForkIdle: begin
                    if (!bus.last_i) begin
                        state_d = ForkLocked;
                        lock_d  = head_mask;
                    end
                end
                ForkLocked: begin
                    if (bus.last_i) begin
                        state_d = ForkIdle;
                    end
                end
                default: state_d = ForkIdle;
            endcase
        end
    end

    // State and locked-mask registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ForkIdle;
            lock_q  <= '0;
        end else begin
            state_q <= state_d;
            lock_q  <= lock_d;
        end
    end

    // Saturating count of flits consumed without any destination.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            drop_cnt_q <= '0;
        end else if (drop && (drop_cnt_q != {CntWidth{1'b1}})) begin
            drop_cnt_q <= drop_cnt_q + CntWidth'(1);
        end
    end

    // Upstream must hold the flit and its sideband until it is consumed.
    a_stable_inputs: assert property (@(posedge clk_i) disable iff (rst_i)
        (bus.valid_i && !bus.ready_o) |=>
            (bus.valid_i && $stable(bus.data_i) && $stable(bus.last_i) && $stable(bus.mask_i)));

    // Our own port never sees a flit when loopback is disabled.
    a_no_loopback: assert property (@(posedge clk_i) disable iff (rst_i)
        ((bus.valid_o & LoopMask) == '0));

endmodule
